iir_frame_sequencer: RTL

Frame-level controller that sequences the IIR filter datapath for one block of samples. On a start pulse it clears the filter history, streams N samples from the sample buffer into the filter, waits out the programmed filter latency, and writes the N aligned outputs into the result buffer. It then pulses done. It sits between the Wishbone register bank (start/config/status) and the filter plus its X/Y sample memories, and replaces free-running index counters.

---
 rtl/iir_frame_sequencer.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/iir_frame_sequencer.sv
// Frame controller for the IIR datapath: clears filter history, streams N samples
// from the X buffer into the filter, and writes the latency-aligned outputs to Y.
module iir_frame_sequencer #(
    parameter int DW      = 32,
    parameter int AW      = 5,
    parameter int MAX_LAT = 16,
    parameter int CLR_CYC = 2
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          start,
    input  logic          abort,
    input  logic [AW:0]   frame_len,
    input  logic [3:0]    lat,
    output logic [AW-1:0] x_addr,
    output logic          x_rd_en,
    input  logic [DW-1:0] x_rdata,
    output logic [DW-1:0] filt_in,
    output logic          filt_in_valid,
    output logic          filt_rst_n,
    input  logic [DW-1:0] filt_out,
    output logic          y_we,
    output logic [AW-1:0] y_addr,
    output logic [DW-1:0] y_wdata,
    output logic          busy,
    output logic          done,
    output logic          start_err,
    output logic [15:0]   frame_cnt
);

    typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;

    localparam logic [AW:0] FULL_LEN = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] ONE      = (AW+1)'(1);
    localparam logic [AW:0] CLR_LAST = (AW+1)'(CLR_CYC - 1);

    state_t               state_q, state_d;
    logic [AW:0]          cnt_q, cnt_d;
    logic [AW:0]          len_q, len_d;
    logic [3:0]           lat_q, lat_d;
    logic [AW:0]          cap_cnt_q, cap_cnt_d;
    logic [MAX_LAT-1:0]   line_q, line_d, line_shift;
    logic [AW-1:0]        x_addr_q, x_addr_d;
    logic                 x_rd_en_q, x_rd_en_d;
    logic                 filt_in_valid_q, filt_in_valid_d;
    logic                 filt_rst_n_q, filt_rst_n_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 start_err_q, start_err_d;
    logic [15:0]          frame_cnt_q, frame_cnt_d;
    logic                 cap;

    // Valid-flag delay line; tap lat-1 lines up with the filter's output for that sample.
    assign line_shift[0] = filt_in_valid_q;
    generate
        for (genvar gi = 1; gi < MAX_LAT; gi++) begin : g_line
            assign line_shift[gi] = line_q[gi-1];
        end
    endgenerate

    assign cap = line_q[lat_q - 4'd1];

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        len_d           = len_q;
        lat_d           = lat_q;
        cap_cnt_d       = cap ? cap_cnt_q + ONE : cap_cnt_q;
        line_d          = line_shift;
        x_addr_d        = x_addr_q;
        x_rd_en_d       = 1'b0;
        filt_in_valid_d = x_rd_en_q;
        frame_cnt_d     = frame_cnt_q;
        start_err_d     = start && (state_q != IDLE) && !abort;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    len_d     = (frame_len > FULL_LEN) ? FULL_LEN : frame_len;
                    lat_d     = (lat == 4'd0) ? 4'd1 : lat;
                    cnt_d     = '0;
                    cap_cnt_d = '0;
                    state_d   = (frame_len == '0) ? DONE : CLEAR;
                end
            end
            CLEAR: begin
                if (cnt_q == CLR_LAST) begin
                    state_d   = FEED;
                    cnt_d     = '0;
                    x_rd_en_d = 1'b1;
                    x_addr_d  = '0;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            FEED: begin
                if (cnt_q + ONE < len_q) begin
                    cnt_d     = cnt_q + ONE;
                    x_rd_en_d = 1'b1;
                    x_addr_d  = x_addr_q + AW'(1);
                end else begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (cap && (cap_cnt_q + ONE == len_q)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (abort && (state_q != IDLE)) begin
            state_d         = IDLE;
            x_rd_en_d       = 1'b0;
            filt_in_valid_d = 1'b0;
            line_d          = '0;
        end

        if (state_d == DONE) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
        done_d       = (state_d == DONE);
        busy_d       = (state_d != IDLE);
        filt_rst_n_d = (state_d != CLEAR);
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            len_q           <= '0;
            lat_q           <= 4'd1;
            cap_cnt_q       <= '0;
            line_q          <= '0;
            x_addr_q        <= '0;
            x_rd_en_q       <= 1'b0;
            filt_in_valid_q <= 1'b0;
            filt_rst_n_q    <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            start_err_q     <= 1'b0;
            frame_cnt_q     <= '0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            len_q           <= len_d;
            lat_q           <= lat_d;
            cap_cnt_q       <= cap_cnt_d;
            line_q          <= line_d;
            x_addr_q        <= x_addr_d;
            x_rd_en_q       <= x_rd_en_d;
            filt_in_valid_q <= filt_in_valid_d;
            filt_rst_n_q    <= filt_rst_n_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            start_err_q     <= start_err_d;
            frame_cnt_q     <= frame_cnt_d;
        end
    end

    // Outside valid cycles the filter sees zeros so its tail flushes cleanly.
    assign filt_in       = filt_in_valid_q ? x_rdata : '0;
    assign filt_in_valid = filt_in_valid_q;
    assign x_addr        = x_addr_q;
    assign x_rd_en       = x_rd_en_q;
    assign filt_rst_n    = filt_rst_n_q;
    assign y_we          = cap;
    assign y_addr        = cap_cnt_q[AW-1:0];
    assign y_wdata       = cap ? filt_out : '0;
    assign busy          = busy_q;
    assign done          = done_q;
    assign start_err     = start_err_q;
    assign frame_cnt     = frame_cnt_q;

endmodule
